// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and the
// rotating priority picker it is built from.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Counter wide enough to hold the value burst_max itself.
  function automatic int burst_cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: returns the first set request at or above
// i_rr_ptr, wrapping past NUM_REQ-1 back to 0.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx
);

  // Walk from lowest to highest priority so the highest-priority hit is
  // the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int unsigned pos;
      pos = int'(i_rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (i_req[pos[ID_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with each grant limited to BURST_MAX accepted words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_MAX  = 4,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int                 CNT_W     = burst_cnt_width(BURST_MAX);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_burst_cnt;

  logic             w_found;
  logic [ID_W-1:0]  w_pick;
  logic [ID_W-1:0]  w_next_ptr;
  logic             w_owner_req;
  logic             w_accept;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  // Write strobe and ack must see the live fifo_full: a registered write
  // would be dropped by the FIFO if full rose in the meantime.
  always_comb begin
    ack         = '0;
    fifo_data   = '0;
    w_owner_req = req[r_grant_id];
    w_accept    = (r_state == GRANT) && w_owner_req && !fifo_full;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant_id == ID_W'(k)) begin
        ack[k] = w_accept;
        if (r_state == GRANT) fifo_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_next_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
  assign fifo_write = w_accept;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (!fifo_full) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (r_burst_cnt == LAST_BEAT) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
          // Full with request held: owner simply stalls.
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter: bursts, rotation,
// backpressure, early release, async reset and a 3-producer random run.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 producers, burst 4 ----------------
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] data_in;
  logic [NR-1:0]    ack;
  logic             fifo_write;
  logic [DW-1:0]    fifo_data;
  logic             fifo_full;
  logic [1:0]       grant_id;
  logic             busy;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .BURST_MAX(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // ---------------- DUT B: 3 producers, burst 1 ----------------
  logic [2:0]  b_req;
  logic [47:0] b_data_in;
  logic [2:0]  b_ack;
  logic        b_write;
  logic [15:0] b_data;
  logic        b_full;
  logic [1:0]  b_gid;
  logic        b_busy;

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .BURST_MAX(1)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (b_req),
    .data_in    (b_data_in),
    .ack        (b_ack),
    .fifo_write (b_write),
    .fifo_data  (b_data),
    .fifo_full  (b_full),
    .grant_id   (b_gid),
    .busy       (b_busy)
  );

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int          cyc;
  int          remaining [NR];
  int          seq       [NR];
  int          en_cyc    [NR];
  logic [31:0] full_pat;

  logic [3:0] ack_log  [64];
  logic       busy_log [64];
  logic [1:0] gid_log  [64];

  logic [DW-1:0] wr_q  [$];
  logic [DW-1:0] exp_q [$];

  // ---------------- scoreboard / checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int p, input int s);
    return 16'(p * 4096 + s);
  endfunction

  // Expected per-cycle values as hex digits, cycle 0 leftmost.
  task automatic check_log(input string tag, input logic [127:0] e, input int n, input bit use_busy);
    for (int c = 0; c < n; c++) begin
      logic [3:0] got;
      logic [3:0] want;
      got  = use_busy ? {3'b000, busy_log[c]} : ack_log[c];
      want = e[(n-1-c)*4 +: 4];
      check_eq($sformatf("%s[%0d]", tag, c), {28'd0, got}, {28'd0, want});
    end
  endtask

  task automatic check_wr_q(input string tag);
    check_eq({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++)
      check_eq($sformatf("%s_word[%0d]", tag, k), {16'd0, wr_q[k]}, {16'd0, exp_q[k]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic update_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i] = (remaining[i] > 0) && (cyc >= en_cyc[i]);
      data_in[i*DW +: DW] = word_of(i, seq[i]);
    end
    fifo_full = (cyc < 32) ? full_pat[cyc] : 1'b0;
  endtask

  // Sample at negedge, advance producers at posedge+1.
  task automatic one_cycle();
    logic [NR-1:0] s_ack;
    @(negedge clk);
    if (cyc < 64) begin
      ack_log[cyc]  = ack;
      busy_log[cyc] = busy;
      gid_log[cyc]  = grant_id;
    end
    check_eq("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    check_eq("write_eq_any_ack", 32'(fifo_write), 32'(|ack));
    check_eq("write_while_full", 32'(fifo_write & fifo_full), 32'd0);
    if (fifo_write) wr_q.push_back(fifo_data);
    s_ack = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (s_ack[i]) begin
        seq[i]++;
        remaining[i]--;
      end
    end
    cyc++;
    update_inputs();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) one_cycle();
  endtask

  task automatic start_test();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 0;
      seq[i]       = 0;
      en_cyc[i]    = 0;
    end
    full_pat = '0;
    cyc      = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req       = '0;
    data_in   = '0;
    fifo_full = 1'b0;
    b_req     = '0;
    b_data_in = '0;
    b_full    = 1'b0;

    // Reset values, applied asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_write", 32'(fifo_write), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_data", 32'(fifo_data), 32'd0);

    // Single requester, 6 words: 4-word burst, idle cycle, 2 more.
    start_test();
    remaining[0] = 6;
    update_inputs();
    #1;
    check_eq("t1_idle_data", 32'(fifo_data), 32'd0);
    check_eq("t1_idle_ack", 32'(ack), 32'd0);
    run_cycles(10);
    check_log("t1_ack", 128'h0111101100, 10, 1'b0);
    check_log("t1_busy", 128'h0111101110, 10, 1'b1);
    check_eq("t1_gid", 32'(gid_log[1]), 32'd0);
    for (int w = 0; w < 6; w++) exp_q.push_back(word_of(0, w));
    check_wr_q("t1");

    // All four requesting: rotation 0,1,2,3 with full bursts, then 0 again.
    start_test();
    for (int i = 0; i < NR; i++) remaining[i] = 5;
    update_inputs();
    run_cycles(34);
    check_log("t2_ack", 128'h0111102222044440888801, 22, 1'b0);
    check_eq("t2_gid1", 32'(gid_log[6]), 32'd1);
    check_eq("t2_gid2", 32'(gid_log[11]), 32'd2);
    check_eq("t2_gid3", 32'(gid_log[16]), 32'd3);
    for (int p = 0; p < NR; p++)
      for (int w = 0; w < 4; w++) exp_q.push_back(word_of(p, w));
    for (int p = 0; p < NR; p++) exp_q.push_back(word_of(p, 4));
    check_wr_q("t2");

    // Backpressure on owner 1: full for cycles 3-7 and 9-10.
    start_test();
    remaining[1] = 8;
    full_pat     = 32'h0000_06F8;
    update_inputs();
    run_cycles(13);
    check_log("t3_ack", 128'h0220000020020, 13, 1'b0);
    check_log("t3_busy", 128'h0111111111110, 13, 1'b1);
    for (int c = 3; c <= 10; c++)
      check_eq($sformatf("t3_gid_hold[%0d]", c), 32'(gid_log[c]), 32'd1);
    for (int w = 0; w < 4; w++) exp_q.push_back(word_of(1, w));
    check_wr_q("t3");

    // Early release by 2 after two words: 3 wins over 0 next.
    start_test();
    remaining[2] = 2;
    remaining[0] = 1;
    remaining[3] = 1;
    en_cyc[0]    = 2;
    en_cyc[3]    = 2;
    update_inputs();
    run_cycles(9);
    check_log("t4_ack", 128'h044008001, 9, 1'b0);
    check_eq("t4_gid3", 32'(gid_log[5]), 32'd3);
    exp_q.push_back(word_of(2, 0));
    exp_q.push_back(word_of(2, 1));
    exp_q.push_back(word_of(3, 0));
    exp_q.push_back(word_of(0, 0));
    check_wr_q("t4");

    // Async reset in the middle of producer 1's burst.
    start_test();
    remaining[1] = 8;
    remaining[0] = 4;
    en_cyc[0]    = 3;
    update_inputs();
    run_cycles(3);
    #1;
    check_eq("t5_pre_ack", 32'(ack), 32'h2);
    check_eq("t5_pre_write", 32'(fifo_write), 32'd1);
    check_eq("t5_pre_data", 32'(fifo_data), 32'(word_of(1, 2)));
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_ack", 32'(ack), 32'd0);
    check_eq("t5_rst_write", 32'(fifo_write), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    en_cyc[0] = 0;
    update_inputs();
    run_cycles(2);
    check_log("t5_post_ack", 128'h01, 2, 1'b0);
    check_eq("t5_post_gid", 32'(gid_log[1]), 32'd0);
    exp_q.push_back(word_of(1, 0));
    exp_q.push_back(word_of(1, 1));
    exp_q.push_back(word_of(0, 0));
    check_wr_q("t5");

    // Random sticky requests and random full on the 3-producer instance.
    begin
      int         bseq     [3];
      int         wait_cnt [3];
      int         max_wait;
      int         total;
      logic       prev_busy;
      logic [2:0] s_b_ack;
      max_wait  = 0;
      total     = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        bseq[i]     = 0;
        wait_cnt[i] = 0;
      end
      for (int t = 0; t < 10000; t++) begin
        for (int i = 0; i < 3; i++) begin
          if (!b_req[i] && $urandom_range(0, 1) == 1) b_req[i] = 1'b1;
          b_data_in[i*16 +: 16] = word_of(i, bseq[i]);
        end
        b_full = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        check_eq("rnd_ack_onehot0", 32'($onehot0(b_ack)), 32'd1);
        check_eq("rnd_write_eq_any_ack", 32'(b_write), 32'(|b_ack));
        check_eq("rnd_write_while_full", 32'(b_write & b_full), 32'd0);
        if (b_busy && !prev_busy) begin
          for (int i = 0; i < 3; i++) begin
            if (b_req[i] && b_gid != 2'(i)) begin
              wait_cnt[i]++;
              if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
          end
        end
        prev_busy = b_busy;
        for (int i = 0; i < 3; i++) begin
          if (b_ack[i]) begin
            check_eq("rnd_ack_has_req", 32'(b_req[i]), 32'd1);
            check_eq("rnd_word", 32'(b_data), 32'(word_of(i, bseq[i])));
            bseq[i]++;
            wait_cnt[i] = 0;
            total++;
          end
        end
        s_b_ack = b_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) if (s_b_ack[i]) b_req[i] = 1'b0;
      end
      check_eq("rnd_fairness", 32'(max_wait <= 6), 32'd1);
      check_eq("rnd_activity", 32'(total > 1000), 32'd1);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one FIFO instance among NUM_REQ independent producers.
- Arbitration is round-robin with bounded bursts: one producer at a time owns the port for up to BURST_MAX accepted words.
- Sits directly in front of the FIFO's write/data_in/full interface; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers; 2..16.
- DATA_WIDTH, 16, word width; equals the FIFO DATA_WIDTH.
- BURST_MAX, 4, maximum words accepted per grant before forced re-arbitration; 1..256.

Ports:
- clk  in  1  rising-edge clock, shared with the FIFO.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- req  in  NUM_REQ  per-producer request; held high while the producer has a word presented.
- data_in  in  NUM_REQ*DATA_WIDTH  packed words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot pulse; word of producer i was written this cycle.
- fifo_write  out  1  to FIFO write.
- fifo_data  out  DATA_WIDTH  to FIFO data_in.
- fifo_full  in  1  from FIFO full.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of the current owner; valid while busy.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
  - busy=0, ack=0, fifo_write=0.
  - Takes effect immediately, mid-burst included; no partial word is written after rst_n falls.
- States: IDLE and GRANT.
- IDLE:
  - If any req bit is set, choose the first set bit searching from rr_ptr upward with wrap.
  - Register it into grant_id, clear burst_cnt, go to GRANT.
  - No write occurs in IDLE, so minimum request-to-first-ack latency is 1 cycle.
- GRANT, accept condition: accept = req[grant_id] && ~fifo_full.
  - fifo_write = accept and ack[grant_id] = accept, both combinational from registered state.
  - fifo_data = data_in slice of grant_id, driven combinationally whenever busy, 0 in IDLE.
  - Combinational drive is mandatory: the FIFO drops writes while full, so a registered write would lose data on a stale full.
- GRANT, on accept:
  - burst_cnt increments.
  - If burst_cnt==BURST_MAX-1, go to IDLE and set rr_ptr=grant_id+1 (wrap at NUM_REQ).
- GRANT, req[grant_id] low (producer finished or withdrew):
  - Go to IDLE with rr_ptr=grant_id+1.
  - No ack that cycle.
- GRANT, fifo_full high with req held: stay in GRANT, no ack, burst_cnt unchanged, no timeout. Backpressure stalls the owner only.
- Every release passes through IDLE for one cycle. Back-to-back grants to different producers are therefore separated by exactly one idle cycle.
- Producer contract: data_in slice stable while req is high and until ack is seen. req may drop at any time without ack; the word is then not written.
- Non-owner req bits are ignored in GRANT and their ack stays 0.
- Fairness: with all producers requesting continuously and the FIFO never full, grants rotate 0,1,..,NUM_REQ-1,0 with BURST_MAX words each.
- Width rules:
  - burst_cnt is clog2(BURST_MAX+1) bits.
  - rr_ptr wrap uses explicit compare against NUM_REQ-1, so non-power-of-2 NUM_REQ is supported.
- Invariants (assert in bench):
  - ack is onehot0.
  - fifo_write == |ack.
  - fifo_write implies ~fifo_full.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - ID-width function max(1, clog2(n));
  - burst counter width constant helper.
- One sub-module: rr_priority_pick.
  - Combinational rotating priority encoder with inputs req and rr_ptr, outputs found and idx.
  - Reused by later read-side schedulers.

Test Plan:
- Single requester: req=0001, FIFO empty, BURST_MAX=4, 6 words.
  - -> grant_id=0 one cycle after req.
  - -> acks on 4 consecutive cycles, 1 idle cycle, then 2 more acks.
  - -> FIFO read back gives the 6 words in order.
- All four requesting continuously, each with a distinct word stream: first 16 writes come from producers 0,0,0,0,1,1,1,1,2,..,3, each group separated by one idle cycle. Then 0 again.
- Backpressure:
  - Fill FIFO to full with producer 1 owning the port -> fifo_write=0, ack=0, grant_id holds 1 while full.
  - Do one read -> exactly one ack to producer 1 the cycle full drops.
- Early release: producer 2 drops req after 2 words with BURST_MAX=4 -> IDLE next cycle, rr_ptr=3, producer 3 granted next although producer 0 is also requesting.
- Async reset mid-burst: assert rst_n low between clock edges during GRANT -> busy, ack, fifo_write go 0 immediately. After release, arbitration restarts from producer 0.
- Random req and fifo_full for 10k cycles, NUM_REQ=3, BURST_MAX=1 -> invariants hold, no word lost or duplicated versus scoreboard, no producer waits more than 2*NUM_REQ grants.
